toggle_event_decoder: RTL and testbench



---
 rtl/toggle_event_decoder.sv | 83 ++++++++
 tb/tb_toggle_event_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event link: synchronises the level, decodes
// each level change into a one-cycle pulse and queues events in a saturating counter.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             toggle_in,
  input  logic             evt_ready,
  input  logic             clr_overflow,
  output logic             evt_pulse,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending_count,
  output logic             overflow,
  output logic             toggle_state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   pop_s;
  logic                   lost_s;

  // Synchroniser chain, edge decode and pending-event state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Pending counter next state: a simultaneous event and pop cancel out,
  // and an event arriving at saturation is dropped and flagged.
  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    lost_s = 1'b0;
    pop_s  = (cnt_q != CNT_ZERO) & evt_ready;
    case ({pulse_q, pop_s})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          lost_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (lost_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  assign evt_pulse     = pulse_q;
  assign evt_valid     = (cnt_q != CNT_ZERO);
  assign pending_count = cnt_q;
  assign overflow      = ovf_q;
  assign toggle_state  = prev_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Randomised bench for toggle_event_decoder against a sample-history reference model.
module tb_toggle_event_decoder;

  localparam int N    = 2;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic          toggle_in;
  logic          evt_ready;
  logic          clr_overflow;
  logic          evt_pulse;
  logic          evt_valid;
  logic [CW-1:0] pending_count;
  logic          overflow;
  logic          toggle_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: toggle_in values seen at each edge, events in flight, queue depth.
  logic samp[$];
  logic m_pulse;
  int   m_cnt;
  logic m_ovf;
  logic lvl;

  toggle_event_decoder #(.SYNC_STAGES(N), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .toggle_in    (toggle_in),
    .evt_ready    (evt_ready),
    .clr_overflow (clr_overflow),
    .evt_pulse    (evt_pulse),
    .evt_valid    (evt_valid),
    .pending_count(pending_count),
    .overflow     (overflow),
    .toggle_state (toggle_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    for (int i = 0; i <= N; i++) samp.push_back(1'b0);
    m_pulse = 1'b0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".pulse"}, {31'd0, evt_pulse}, {31'd0, m_pulse});
    check_eq({ph, ".valid"}, {31'd0, evt_valid}, (m_cnt != 0) ? 32'd1 : 32'd0);
    check_eq({ph, ".count"}, {28'd0, pending_count}, m_cnt);
    check_eq({ph, ".ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
    check_eq({ph, ".level"}, {31'd0, toggle_state}, {31'd0, samp[samp.size()-1-N]});
  endtask

  task automatic check_zero(input string ph);
    check_eq({ph, ".pulse"}, {31'd0, evt_pulse}, 32'd0);
    check_eq({ph, ".valid"}, {31'd0, evt_valid}, 32'd0);
    check_eq({ph, ".count"}, {28'd0, pending_count}, 32'd0);
    check_eq({ph, ".ovf"}, {31'd0, overflow}, 32'd0);
    check_eq({ph, ".level"}, {31'd0, toggle_state}, 32'd0);
  endtask

  // One clock: drive inputs, advance the model by the rules, check just after the edge.
  task automatic step(input string ph, input logic t, input logic r, input logic c);
    logic pop;
    logic set;
    toggle_in    = t;
    evt_ready    = r;
    clr_overflow = c;
    @(posedge clk);
    pop = (m_cnt != 0) && r;
    set = 1'b0;
    if (m_pulse && !pop) begin
      if (m_cnt == MAXC) set = 1'b1;
      else m_cnt++;
    end else if (!m_pulse && pop) begin
      m_cnt--;
    end
    m_ovf = set ? 1'b1 : (c ? 1'b0 : m_ovf);
    samp.push_back(t);
    if (samp.size() > N + 2) void'(samp.pop_front());
    m_pulse = (samp[samp.size()-1-N] != samp[samp.size()-2-N]);
    #1;
    check_all(ph);
  endtask

  initial begin
    reset_n      = 1'b0;
    toggle_in    = 1'b0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    lvl          = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    reset_n = 1'b1;

    // Single event: pulse two edges after capture, then queued.
    lvl = 1'b1;
    for (int i = 0; i < 6; i++) step("single", lvl, 1'b0, 1'b0);
    check_eq("single.count_final", {28'd0, pending_count}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) lvl = ~lvl;
      step("randA", lvl, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    // Saturate with no consumer, then clear overflow with no event in flight.
    for (int i = 0; i < 20; i++) begin
      lvl = ~lvl;
      for (int j = 0; j < 4; j++) step("sat", lvl, 1'b0, 1'b0);
    end
    check_eq("sat.count_max", {28'd0, pending_count}, MAXC);
    check_eq("sat.ovf_set", {31'd0, overflow}, 32'd1);
    step("clr", lvl, 1'b0, 1'b1);
    step("clr", lvl, 1'b0, 1'b0);
    check_eq("clr.ovf_cleared", {31'd0, overflow}, 32'd0);

    // Clear held across the cycle of a lost event: the set must win.
    lvl = ~lvl;
    for (int j = 0; j < 4; j++) step("clrset", lvl, 1'b0, 1'b1);
    for (int j = 0; j < 2; j++) step("clrset", lvl, 1'b0, 1'b0);
    check_eq("clrset.ovf_kept", {31'd0, overflow}, 32'd1);

    for (int j = 0; j < 10; j++) step("pop10", lvl, 1'b1, 1'b0);
    check_eq("pop10.count", {28'd0, pending_count}, 32'd5);

    // Asynchronous reset between edges, released with the link at 1.
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    lvl       = 1'b1;
    toggle_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) step("post_rst", lvl, 1'b0, 1'b0);
    check_eq("post_rst.one_event", {28'd0, pending_count}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) lvl = ~lvl;
      step("randB", lvl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 25; i++) step("drain", lvl, 1'b1, 1'b0);
    check_eq("drain.empty", {31'd0, evt_valid}, 32'd0);
    step("underflow", lvl, 1'b1, 1'b0);
    check_eq("underflow.count", {28'd0, pending_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
